// File: rtl/regfile_dbg_pkg.sv
// Shared encodings and default sizes for the register-file debug/initialisation port.
package regfile_dbg_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DUMP = 3'd3,
        ST_CLR  = 3'd4,
        ST_RESP = 3'd5
    } state_e;

endpackage

// File: rtl/regfile_debug_port.sv
// Debug initiator for the 2R/1W register file: single read/write, full dump and
// clear of x1..x(NREGS-1), results returned on a valid/ready response channel.
module regfile_debug_port
    import regfile_dbg_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [XLEN-1:0]   cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_last,
    output logic              stall_core,
    output logic [ADDR_W-1:0] rf_a1,
    input  logic [XLEN-1:0]   rf_rd1,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_wd3,
    output logic              rf_we3
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic                r_cmd_ready;
    logic                r_stall;
    logic                r_rsp_valid;
    logic [ADDR_W-1:0]   r_rsp_addr;
    logic [XLEN-1:0]     r_rsp_data;
    logic                r_rsp_last;
    logic [ADDR_W-1:0]   r_rf_a1;
    logic [ADDR_W-1:0]   r_rf_a3;
    logic [XLEN-1:0]     r_rf_wd3;
    logic                r_rf_we3;
    logic [ADDR_W-1:0]   w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + ADDR_W'(1);

    // RF address/write controls are registered one cycle ahead so they are valid
    // for the whole RD/WR/DUMP/CLR cycle that consumes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cmd_ready <= 1'b1;
            r_stall     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
            r_rf_a1     <= '0;
            r_rf_a3     <= '0;
            r_rf_wd3    <= '0;
            r_rf_we3    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_cmd_ready <= 1'b0;
                        r_stall     <= 1'b1;
                        case (op_e'(cmd_op))
                            OP_READ: begin
                                r_rf_a1 <= cmd_addr;
                                r_state <= ST_RD;
                            end
                            OP_WRITE: begin
                                r_rf_a3  <= cmd_addr;
                                r_rf_wd3 <= cmd_wdata;
                                r_rf_we3 <= 1'b1;
                                r_state  <= ST_WR;
                            end
                            OP_DUMP: begin
                                r_cnt   <= '0;
                                r_rf_a1 <= '0;
                                r_state <= ST_DUMP;
                            end
                            OP_CLEAR: begin
                                r_cnt    <= ADDR_W'(1);
                                r_rf_a3  <= ADDR_W'(1);
                                r_rf_wd3 <= '0;
                                r_rf_we3 <= 1'b1;
                                r_state  <= ST_CLR;
                            end
                        endcase
                    end
                end

                ST_RD: begin
                    r_rsp_data  <= rf_rd1;
                    r_rsp_addr  <= r_addr;
                    r_rsp_last  <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end

                // x0 write still reaches the RF, which discards it; the ack reports 0.
                ST_WR: begin
                    r_rf_we3    <= 1'b0;
                    r_rsp_data  <= (r_addr == '0) ? '0 : r_wdata;
                    r_rsp_addr  <= r_addr;
                    r_rsp_last  <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end

                ST_DUMP: begin
                    r_rsp_data  <= rf_rd1;
                    r_rsp_addr  <= r_cnt;
                    r_rsp_last  <= (r_cnt == LAST_IDX);
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end

                ST_CLR: begin
                    if (r_cnt == LAST_IDX) begin
                        r_rf_we3    <= 1'b0;
                        r_rsp_data  <= '0;
                        r_rsp_addr  <= LAST_IDX;
                        r_rsp_last  <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt   <= w_cnt_nxt;
                        r_rf_a3 <= w_cnt_nxt;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_last) begin
                            r_rsp_last  <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_stall     <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_cnt   <= w_cnt_nxt;
                            r_rf_a1 <= w_cnt_nxt;
                            r_state <= ST_DUMP;
                        end
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_stall     <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_rf_we3    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign stall_core = r_stall;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_addr   = r_rsp_addr;
    assign rsp_data   = r_rsp_data;
    assign rsp_last   = r_rsp_last;
    assign rf_a1      = r_rf_a1;
    assign rf_a3      = r_rf_a3;
    assign rf_wd3     = r_rf_wd3;
    assign rf_we3     = r_rf_we3;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Self-checking bench for regfile_debug_port with a behavioural RF and a command-level model.
module tb_regfile_debug_port;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int OP_RD = 0, OP_WR = 1, OP_DP = 2, OP_CL = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [AW-1:0]   cmd_addr;
    logic [XLEN-1:0] cmd_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [AW-1:0]   rsp_addr;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_last;
    logic            stall_core;
    logic [AW-1:0]   rf_a1;
    logic [XLEN-1:0] rf_rd1;
    logic [AW-1:0]   rf_a3;
    logic [XLEN-1:0] rf_wd3;
    logic            rf_we3;

    always #5 clk = ~clk;

    regfile_debug_port dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .stall_core(stall_core),
        .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3)
    );

    // Behavioural 2R/1W register file: combinational read, x0 hardwired to zero.
    logic [XLEN-1:0] rf_mem [NREGS];
    always @(posedge clk) if (rf_we3 && rf_a3 != '0) rf_mem[rf_a3] <= rf_wd3;
    assign rf_rd1 = (rf_a1 == '0) ? '0 : rf_mem[rf_a1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Log of every RF write cycle observed.
    int              we_a [$];
    logic [XLEN-1:0] we_d [$];
    int              we_c [$];
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rf_we3) begin
            we_a.push_back(int'(rf_a3));
            we_d.push_back(rf_wd3);
            we_c.push_back(cyc);
        end
    end

    // Expected architectural contents as seen through commands.
    logic [XLEN-1:0] ref_rf [NREGS];

    int              got_a [$];
    logic [XLEN-1:0] got_d [$];
    bit              got_l [$];

    typedef struct {
        int              op;
        int              addr;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] exp_data;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic issue(input int op, input int addr, input logic [XLEN-1:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_addr  = AW'(addr);
        cmd_wdata = wd;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            timeout("cmd_accept");
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    // Gathers responses up to the one flagged last; checks hold-stability while stalled.
    task automatic collect(input bit toggle);
        bit done;
        bit pv, pr, pl;
        logic [AW-1:0] pa;
        logic [XLEN-1:0] pd;
        int n;
        got_a.delete(); got_d.delete(); got_l.delete();
        done = 0; pv = 0; pr = 0; pl = 0; pa = '0; pd = '0; n = 0;
        rsp_ready = 1'b0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            if (pv && !pr) begin
                check("hold_valid", 64'(rsp_valid), 64'(1));
                check("hold_addr", 64'(rsp_addr), 64'(pa));
                check("hold_data", 64'(rsp_data), 64'(pd));
                check("hold_last", 64'(rsp_last), 64'(pl));
            end
            rsp_ready = toggle ? ~rsp_ready : 1'b1;
            if (rsp_valid && rsp_ready) begin
                got_a.push_back(int'(rsp_addr));
                got_d.push_back(rsp_data);
                got_l.push_back(rsp_last);
                if (rsp_last) done = 1;
            end
            pv = rsp_valid; pr = rsp_ready; pa = rsp_addr; pd = rsp_data; pl = rsp_last;
        end
        if (done) begin
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end else begin
            rsp_ready = 1'b0;
            timeout("rsp_last");
        end
    endtask

    // Compares collected responses and RF writes with what the model predicts, then updates it.
    task automatic verify(input int op, input int addr, input logic [XLEN-1:0] wd, input string name);
        int              ea [$];
        logic [XLEN-1:0] ed [$];
        int              xa [$];
        logic [XLEN-1:0] xd [$];
        int              m;
        case (op)
            OP_RD: begin ea.push_back(addr); ed.push_back(ref_rf[addr]); end
            OP_WR: begin
                ea.push_back(addr); ed.push_back(addr == 0 ? '0 : wd);
                xa.push_back(addr); xd.push_back(wd);
            end
            OP_DP: for (int i = 0; i < int'(NREGS); i++) begin ea.push_back(i); ed.push_back(ref_rf[i]); end
            default: begin
                ea.push_back(int'(NREGS) - 1); ed.push_back('0);
                for (int i = 1; i < int'(NREGS); i++) begin xa.push_back(i); xd.push_back('0); end
            end
        endcase
        check({name, "_nrsp"}, 64'(got_a.size()), 64'(ea.size()));
        m = (got_a.size() < ea.size()) ? got_a.size() : ea.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_addr%0d", name, i), 64'(got_a[i]), 64'(ea[i]));
            check($sformatf("%s_data%0d", name, i), 64'(got_d[i]), 64'(ed[i]));
            check($sformatf("%s_last%0d", name, i), 64'(got_l[i]), 64'(i == ea.size() - 1));
        end
        check({name, "_nwr"}, 64'(we_a.size()), 64'(xa.size()));
        m = (we_a.size() < xa.size()) ? we_a.size() : xa.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_wa%0d", name, i), 64'(we_a[i]), 64'(xa[i]));
            check($sformatf("%s_wd%0d", name, i), 64'(we_d[i]), 64'(xd[i]));
            if (op == OP_CL) check($sformatf("%s_wc%0d", name, i), 64'(we_c[i]), 64'(we_c[0] + i));
        end
        if (op == OP_WR && addr != 0) ref_rf[addr] = wd;
        if (op == OP_CL) for (int i = 0; i < int'(NREGS); i++) ref_rf[i] = '0;
    endtask

    task automatic run_cmd(input int op, input int addr, input logic [XLEN-1:0] wd,
                           input bit toggle, input string name);
        we_a.delete(); we_d.delete(); we_c.delete();
        issue(op, addr, wd);
        collect(toggle);
        verify(op, addr, wd, name);
    endtask

    initial begin
        int n;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < int'(NREGS); i++) ref_rf[i] = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_last", 64'(rsp_last), 64'(0));
        check("rst_rsp_addr", 64'(rsp_addr), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_stall", 64'(stall_core), 64'(0));
        check("rst_a1", 64'(rf_a1), 64'(0));
        check("rst_a3", 64'(rf_a3), 64'(0));
        check("rst_wd3", 64'(rf_wd3), 64'(0));
        check("rst_we3", 64'(rf_we3), 64'(0));
        reset = 1'b0;

        run_cmd(OP_CL, 0, '0, 0, "init_clr");
        run_cmd(OP_WR, 5, 32'hDEADBEEF, 0, "pre5");

        // READ latency: accept edge N, response visible after edge N+1.
        we_a.delete(); we_d.delete(); we_c.delete();
        issue(OP_RD, 5, '0);
        check("lat_valid_n", 64'(rsp_valid), 64'(0));
        check("lat_stall", 64'(stall_core), 64'(1));
        check("lat_ready", 64'(cmd_ready), 64'(0));
        @(posedge clk);
        #1;
        check("lat_valid_n1", 64'(rsp_valid), 64'(1));
        check("lat_addr", 64'(rsp_addr), 64'(5));
        check("lat_data", 64'(rsp_data), 64'(32'hDEADBEEF));
        collect(0);
        verify(OP_RD, 5, '0, "lat");

        // Directed single-op vectors.
        tbl[0] = '{OP_WR,  7, 32'h12345678, 32'h12345678};
        tbl[1] = '{OP_RD,  7, 32'h0,        32'h12345678};
        tbl[2] = '{OP_WR,  0, 32'hFFFFFFFF, 32'h0};
        tbl[3] = '{OP_RD,  0, 32'h0,        32'h0};
        tbl[4] = '{OP_WR, 31, 32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[5] = '{OP_RD, 31, 32'h0,        32'hA5A5A5A5};
        tbl[6] = '{OP_RD,  5, 32'h0,        32'hDEADBEEF};
        foreach (tbl[k]) begin
            run_cmd(tbl[k].op, tbl[k].addr, tbl[k].wdata, 0, $sformatf("tbl%0d", k));
            if (got_d.size() > 0) check($sformatf("tbl%0d_exp", k), 64'(got_d[0]), 64'(tbl[k].exp_data));
        end

        // Random single reads/writes against the model.
        for (int k = 0; k < 40; k++)
            run_cmd(int'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)), $urandom,
                    1'($urandom_range(0, 1)), "rnd");

        // DUMP with xi = i*0x11 under a toggling consumer.
        for (int i = 1; i < int'(NREGS); i++) run_cmd(OP_WR, i, XLEN'(i * 'h11), 0, "fill");
        run_cmd(OP_DP, 0, '0, 1, "dump");

        // CLEAR after random fill, then a dump of zeros.
        for (int k = 0; k < 12; k++) run_cmd(OP_WR, int'($urandom_range(0, NREGS - 1)), $urandom, 0, "rfill");
        run_cmd(OP_CL, 0, '0, 0, "clr");
        run_cmd(OP_DP, 0, '0, 0, "dump0");

        // Reset while DUMP presents address 12.
        for (int i = 1; i < int'(NREGS); i++) run_cmd(OP_WR, i, $urandom, 0, "fill2");
        issue(OP_DP, 0, '0);
        n = 0;
        rsp_ready = 1'b0;
        while (n < 500) begin
            @(negedge clk);
            n++;
            if (rsp_valid && rsp_addr == AW'(12)) break;
            rsp_ready = 1'b1;
        end
        if (n >= 500) timeout("dump_to_12");
        rsp_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("mid_rst_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_ready", 64'(cmd_ready), 64'(1));
        check("mid_rst_stall", 64'(stall_core), 64'(0));
        check("mid_rst_we3", 64'(rf_we3), 64'(0));
        check("mid_rst_last", 64'(rsp_last), 64'(0));
        run_cmd(OP_RD, 12, '0, 0, "post_rst_rd");

        // A different command held valid through a DUMP waits until IDLE.
        we_a.delete(); we_d.delete(); we_c.delete();
        issue(OP_DP, 0, '0);
        cmd_valid = 1'b1; cmd_op = 2'(OP_RD); cmd_addr = AW'(9); cmd_wdata = '0;
        collect(1);
        verify(OP_DP, 0, '0, "held_dump");
        check("held_idle_ready", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("held_accept", 64'(stall_core), 64'(1));
        we_a.delete(); we_d.delete(); we_c.delete();
        collect(0);
        verify(OP_RD, 9, '0, "held_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
